// File: rtl/keypad_encoder_p_if.sv
// Key bus and encoder result bundle between the numpad front end and the time-register logic.
// master drives keys/enable and consumes the encoded result; slave is the encoder side.
interface keypad_encoder_p_if #(
  parameter int NUM_KEYS = 10,
  parameter int CODE_W   = 4
);
  logic [NUM_KEYS-1:0] keys;
  logic                enable;
  logic [CODE_W-1:0]   code;
  logic                loadn;
  logic                key_valid;
  logic                multi_err;
  logic                pgt_tick;

  modport master (
    output keys, enable,
    input  code, loadn, key_valid, multi_err, pgt_tick
  );

  modport slave (
    input  keys, enable,
    output code, loadn, key_valid, multi_err, pgt_tick
  );
endinterface

// File: rtl/keypad_encoder_p.sv
// Debouncing lowest-key encoder with load strobe and counter clock-enable (strobe or divided timebase).
// Optional auto-repeat while a key is held: define AUTO_REPEAT_EN.
module keypad_encoder_p #(
  parameter int NUM_KEYS        = 10,
  parameter int CODE_W          = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int DIV             = 100,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
) (
  input  logic               clk,
  input  logic               clear,
  keypad_encoder_p_if.slave  bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DEBOUNCE = 3'd1;
  localparam logic [2:0] S_FIRE     = 3'd2;
  localparam logic [2:0] S_HOLD     = 3'd3;
  localparam logic [2:0] S_RELEASE  = 3'd4;

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DIV_W = $clog2(DIV);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

`ifdef AUTO_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  generate
    if (NUM_KEYS < 2 || CODE_W < $clog2(NUM_KEYS) || DEBOUNCE_CYCLES < 1 || DIV < 2 ||
        (REPEAT_ON && (REPEAT_DELAY < 1 || REPEAT_PERIOD < 2))) begin : g_bad_params
      $error("keypad_encoder_p: illegal parameter set");
    end
  endgenerate

  logic [2:0]          state_reg, state_next;
  logic [NUM_KEYS-1:0] sample_reg, sample_next;
  logic [DB_W-1:0]     cnt_reg, cnt_next;
  logic [CODE_W-1:0]   code_reg, code_next;
  logic                multi_reg, multi_next;
  logic [DIV_W-1:0]    div_reg, div_next;
  logic                loadn_reg, key_valid_reg, tick_reg;
  logic [CODE_W-1:0]   low_idx;
  logic                sample_multi;
  logic                keys_nz;

  assign keys_nz      = |bus.keys;
  assign sample_multi = |(sample_reg & (sample_reg - NUM_KEYS'(1)));

  always_comb begin
    low_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (sample_reg[i]) low_idx = CODE_W'(i);
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX);
  logic [RPT_W-1:0] rpt_reg, rpt_next;
  logic             rpt_again_reg, rpt_again_next;
  logic             rpt_due;
  // A repeat period includes its own FIRE cycle, so the hold part is one shorter.
  assign rpt_due = rpt_again_reg ? (rpt_reg == RPT_W'(REPEAT_PERIOD - 2))
                                 : (rpt_reg == RPT_W'(REPEAT_DELAY - 1));
`endif

  always_comb begin
    state_next  = state_reg;
    sample_next = sample_reg;
    cnt_next    = cnt_reg;
    code_next   = code_reg;
    multi_next  = multi_reg;
`ifdef AUTO_REPEAT_EN
    rpt_next       = rpt_reg;
    rpt_again_next = rpt_again_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (keys_nz) begin
          sample_next = bus.keys;
          cnt_next    = '0;
          state_next  = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (!keys_nz) begin
          state_next = S_IDLE;
        end else if (bus.keys != sample_reg) begin
          sample_next = bus.keys;
          cnt_next    = '0;
        end else if (cnt_reg == DB_LAST) begin
          state_next = S_FIRE;
          code_next  = low_idx;
          multi_next = sample_multi;
`ifdef AUTO_REPEAT_EN
          rpt_again_next = 1'b0;
`endif
        end else begin
          cnt_next = cnt_reg + DB_W'(1);
        end
      end
      S_FIRE: begin
        state_next = S_HOLD;
`ifdef AUTO_REPEAT_EN
        rpt_next = '0;
`endif
      end
      S_HOLD: begin
        // Changes among nonzero keys are deliberately ignored (n-key lockout).
        if (!keys_nz) begin
          cnt_next   = '0;
          state_next = S_RELEASE;
        end
`ifdef AUTO_REPEAT_EN
        else if (rpt_due) begin
          state_next     = S_FIRE;
          rpt_again_next = 1'b1;
        end else begin
          rpt_next = rpt_reg + RPT_W'(1);
        end
`endif
      end
      S_RELEASE: begin
        if (keys_nz) begin
          state_next = S_HOLD;
`ifdef AUTO_REPEAT_EN
          rpt_next       = '0;
          rpt_again_next = 1'b0;
`endif
        end else if (cnt_reg == DB_LAST) begin
          multi_next = 1'b0;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg + DB_W'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
    // A disabled keypad overrides everything; code and multi_err keep their last values.
    if (!bus.enable) begin
      state_next = S_IDLE;
      code_next  = code_reg;
      multi_next = multi_reg;
    end
  end

  always_comb begin
    div_next = '0;
    if (!bus.enable) div_next = (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_reg     <= S_IDLE;
      sample_reg    <= '0;
      cnt_reg       <= '0;
      code_reg      <= '0;
      multi_reg     <= 1'b0;
      div_reg       <= '0;
      loadn_reg     <= 1'b1;
      key_valid_reg <= 1'b0;
      tick_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sample_reg    <= sample_next;
      cnt_reg       <= cnt_next;
      code_reg      <= code_next;
      multi_reg     <= multi_next;
      div_reg       <= div_next;
      loadn_reg     <= (state_next != S_FIRE);
      key_valid_reg <= (state_next == S_FIRE) || (state_next == S_HOLD) ||
                       (state_next == S_RELEASE);
      tick_reg      <= (state_next == S_FIRE) || (!bus.enable && (div_reg == DIV_LAST));
    end
  end

`ifdef AUTO_REPEAT_EN
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      rpt_reg       <= '0;
      rpt_again_reg <= 1'b0;
    end else begin
      rpt_reg       <= rpt_next;
      rpt_again_reg <= rpt_again_next;
    end
  end
`endif

  assign bus.code      = code_reg;
  assign bus.loadn     = loadn_reg;
  assign bus.key_valid = key_valid_reg;
  assign bus.multi_err = multi_reg;
  assign bus.pgt_tick  = tick_reg;

endmodule

// File: doc/keypad_encoder_p.md
# keypad_encoder_p

Parametrised keypad front end for the microwave controller: debounces a NUM_KEYS-wide active-high key bus, encodes the lowest pressed key to a binary code with a one-cycle active-low load strobe, and supplies the counter clock-enable pulse. While the keypad is enabled, that pulse follows key strobes; while disabled, it is a divided timebase tick. It sits between the numpad inputs and the BCD time-register/countdown logic, and supersedes the fixed 10-key encoder.

## Interface
- NUM_KEYS, 10: key lines; must be ≥2.
- CODE_W, 4: code width; must be ≥ clog2(NUM_KEYS).
- DEBOUNCE_CYCLES, 8: consecutive stable cycles required for press and release; must be ≥1.
- DIV, 100: timebase divide ratio; must be ≥2.
- REPEAT_DELAY, 500: cycles held before first auto-repeat (AUTO_REPEAT builds only).
- REPEAT_PERIOD, 100: cycles between subsequent repeats (AUTO_REPEAT builds only).
- clk  in  1  system clock, rising edge.
- clear  in  1  reset, asynchronous, active-high.
- keys  in  NUM_KEYS  raw key lines, bit i = key i, active-high, externally synchronised.
- enable  in  1  1 = keypad accepted; 0 = keys ignored, timebase running.
- code  out  CODE_W  index of accepted key, zero-extended.
- loadn  out  1  active-low load strobe, one cycle per accepted press.
- key_valid  out  1  accepted key currently held.
- multi_err  out  1  more than one bit set in debounced sample.
- pgt_tick  out  1  one-cycle clock-enable pulse.

## Operation
- All outputs registered. Reset values: code=0, loadn=1, key_valid=0, multi_err=0, pgt_tick=0; FSM in IDLE; debounce, repeat, and divider counters=0.
- FSM states:
  - IDLE: if keys≠0, capture sample=keys, set cnt=0, and go to DEBOUNCE.
  - DEBOUNCE: if keys==0, go to IDLE. If keys≠sample, recapture the sample and set cnt=0. Otherwise cnt++; when cnt reaches DEBOUNCE_CYCLES-1, go to FIRE.
  - FIRE (1 cycle): code=index of lowest set bit of sample; multi_err=(popcount(sample)>1); then go to HOLD.
  - HOLD: n-key lockout; changes among nonzero keys are ignored. When keys==0, set cnt=0 and go to RELEASE.
  - RELEASE: if keys≠0, return to HOLD. After DEBOUNCE_CYCLES consecutive zero cycles, clear multi_err and go to IDLE.
- Outputs by state:
  - loadn=0 exactly while in FIRE.
  - key_valid=1 in FIRE, HOLD, and RELEASE.
  - code holds its value until the next FIRE.
- enable=0: the FSM is forced to IDLE synchronously. This drops key_valid, and no strobes occur.
- Divider:
  - Counts 0..DIV-1 only while enable=0, and clears to 0 whenever enable=1.
  - It emits a pulse in the cycle after the counter reaches DIV-1.
- pgt_tick selection:
  - enable=1: pgt_tick mirrors the FIRE strobe (pgt_tick=~loadn).
  - enable=0: pgt_tick is the divider pulse.
  - Selection is registered, so no glitch or double pulse occurs on an enable edge.

## Timing
- Press latency: loadn goes low in the cycle after the (DEBOUNCE_CYCLES+1)th rising edge, counting from the edge that first samples a stable nonzero keys value.
- Release: a new press is accepted no sooner than DEBOUNCE_CYCLES cycles after keys returns to 0.
- Timebase period: DIV cycles. The first tick comes DIV cycles after enable falls.
- clear mid-debounce or mid-HOLD: returns to reset values immediately, and no strobe is issued.
- Simultaneous keys change and counter terminal in DEBOUNCE: the change wins (the count restarts).

## Configuration
- AUTO_REPEAT_EN defined:
  - In HOLD, after REPEAT_DELAY cycles held, the FSM re-enters FIRE (code unchanged).
  - It then re-enters FIRE every REPEAT_PERIOD cycles until release.
  - The repeat counter clears on entry to HOLD from FIRE and on return from RELEASE.
- AUTO_REPEAT_EN undefined: exactly one strobe per press. REPEAT_* parameters are ignored, and no repeat counter is synthesised.

## Test plan
All scenarios use NUM_KEYS=10, DEBOUNCE_CYCLES=4, DIV=5, enable=1 unless stated.
- Reset: clear=1 asynchronously mid-cycle -> code=0, loadn=1, key_valid=0, multi_err=0, pgt_tick=0 immediately.
- Clean press: keys=10'b0000001000 held for 20 cycles -> a single loadn low pulse 5 edges after first sample, code=3, pgt_tick pulses in the same cycle, key_valid=1 until 4 cycles after release.
- Bounce: keys toggles 0/bit7 every 2 cycles for 10 cycles, then holds bit7 -> no strobe during bouncing, then one strobe with code=7, 5 edges after the stable hold begins.
- Multi-key: keys=10'b0000100100 -> code=2, multi_err=1; after release plus 4 cycles, multi_err=0.
- Timebase: enable=0 with keys toggling -> no loadn, pgt_tick pulses every 5 cycles; raising enable produces no spurious tick.
- Auto-repeat (AUTO_REPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=10): key 9 held for 60 cycles -> strobes at initial, +21, +31, +41, +51 cycles, all code=9; with the macro undefined, a single strobe only.
